// File: rtl/ecg_pkg.sv
// ecg_pkg: shared definitions for the ECG peak-detection path.
//   FP32_W           width of an IEEE-754 single-precision word
//   REFRACT_DEFAULT  default refractory length in samples (200 ms at 360 Hz)
//   ST_*             peak-detector FSM encodings
package ecg_pkg;

    localparam int unsigned FP32_W          = 32;
    localparam int unsigned REFRACT_DEFAULT = 72;

    localparam logic [1:0] ST_ARMED   = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_REFRACT = 2'd2;

endpackage

// File: rtl/ecg_peak_detector_fp32_cmp.sv
// ecg_peak_detector_fp32_cmp: combinational float32 "a > b" compare.
//   a, b  in   float32 operands
//   gt    out  a strictly greater than b
// Pure sign-magnitude ordering: +0 is greater than -0, and NaN/Inf are ordered by their
// bit patterns rather than being special-cased.
module ecg_peak_detector_fp32_cmp
    import ecg_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic              gt
);

    always_comb begin
        unique case ({a[FP32_W-1], b[FP32_W-1]})
            2'b00:   gt = a[FP32_W-2:0] > b[FP32_W-2:0];
            2'b01:   gt = 1'b1;
            2'b10:   gt = 1'b0;
            // Both negative: smaller magnitude is the larger value.
            default: gt = a[FP32_W-2:0] < b[FP32_W-2:0];
        endcase
    end

endmodule

// File: rtl/ecg_peak_detector.sv
// ecg_peak_detector: streaming R-peak detector on float32 samples.
//   clk, rst     single clock, synchronous active-high reset
//   s_valid/s_ready/s_data   input sample stream (one sample per accepted beat)
//   threshold    float32 detection level, read on every accepted beat
//   m_valid/m_ready          peak record handshake
//   m_peak_val   float32 peak amplitude of the excursion
//   m_peak_idx   sample index of the peak
// One record is emitted per excursion above threshold, when the signal falls back to or
// below threshold. After each record, REFRACT accepted samples are ignored, and a new
// excursion can only start once the signal has dropped to or below threshold.
module ecg_peak_detector
    import ecg_pkg::*;
#(
    parameter int unsigned REFRACT = REFRACT_DEFAULT,
    parameter int unsigned IDX_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [FP32_W-1:0] s_data,
    input  logic [FP32_W-1:0] threshold,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [FP32_W-1:0] m_peak_val,
    output logic [IDX_W-1:0]  m_peak_idx
);

    localparam int unsigned CNT_W = $clog2(REFRACT + 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [FP32_W-1:0] run_max_q, run_max_d;
    logic [IDX_W-1:0]  run_idx_q, run_idx_d;
    logic              m_valid_q, m_valid_d;
    logic [FP32_W-1:0] peak_val_q, peak_val_d;
    logic [IDX_W-1:0]  peak_idx_q, peak_idx_d;

    logic accept;
    logic above_thr;
    logic above_max;

    ecg_peak_detector_fp32_cmp u_cmp_thr (
        .a  (s_data),
        .b  (threshold),
        .gt (above_thr)
    );

    ecg_peak_detector_fp32_cmp u_cmp_max (
        .a  (s_data),
        .b  (run_max_q),
        .gt (above_max)
    );

    // Stall input only while a record is waiting; m_ready bypass keeps throughput at 1/cycle.
    assign s_ready = !(m_valid_q && !m_ready);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        run_max_d  = run_max_q;
        run_idx_d  = run_idx_q;
        m_valid_d  = m_valid_q;
        peak_val_d = peak_val_q;
        peak_idx_d = peak_idx_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (accept) begin
            idx_d = idx_q + IDX_W'(1);
            case (state_q)
                ST_ARMED: begin
                    if (above_thr) begin
                        run_max_d = s_data;
                        run_idx_d = idx_q;
                        state_d   = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (!above_thr) begin
                        m_valid_d  = 1'b1;
                        peak_val_d = run_max_q;
                        peak_idx_d = run_idx_q;
                        cnt_d      = CNT_W'(REFRACT - 1);
                        state_d    = ST_REFRACT;
                    end else if (above_max) begin
                        // Strict compare: ties keep the earlier index.
                        run_max_d = s_data;
                        run_idx_d = idx_q;
                    end
                end
                ST_REFRACT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (!above_thr) begin
                        // Re-arm only after a drop, so a plateau cannot re-trigger.
                        state_d = ST_ARMED;
                    end
                end
                default: begin
                    state_d = ST_ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARMED;
            idx_q      <= '0;
            cnt_q      <= '0;
            run_max_q  <= '0;
            run_idx_q  <= '0;
            m_valid_q  <= 1'b0;
            peak_val_q <= '0;
            peak_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            run_max_q  <= run_max_d;
            run_idx_q  <= run_idx_d;
            m_valid_q  <= m_valid_d;
            peak_val_q <= peak_val_d;
            peak_idx_q <= peak_idx_d;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_peak_val = peak_val_q;
    assign m_peak_idx = peak_idx_q;

endmodule

// File: tb/tb_ecg_peak_detector.sv
module tb_ecg_peak_detector;

    localparam logic [31:0] F_ZERO  = 32'h0000_0000;
    localparam logic [31:0] F_NZERO = 32'h8000_0000;
    localparam logic [31:0] F_HALF  = 32'h3F00_0000;
    localparam logic [31:0] F_ONE   = 32'h3F80_0000;
    localparam logic [31:0] F_1P5   = 32'h3FC0_0000;
    localparam logic [31:0] F_TWO   = 32'h4000_0000;
    localparam logic [31:0] F_THREE = 32'h4040_0000;
    localparam logic [31:0] F_NONE  = 32'hBF80_0000;
    localparam logic [31:0] F_NTWO  = 32'hC000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b1;
    logic [31:0] s_data = '0;
    logic [31:0] threshold = '0;

    logic        s_ready, s_ready_w;
    logic        m_valid, m_valid_w;
    logic [31:0] m_peak_val, m_peak_val_w;
    logic [3:0]  m_peak_idx;
    logic [31:0] m_peak_idx_w;

    // Narrow-index instance exercises wrap; wide instance checks full-width indices.
    ecg_peak_detector #(.REFRACT(4), .IDX_W(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .threshold  (threshold),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_peak_val (m_peak_val),
        .m_peak_idx (m_peak_idx)
    );

    ecg_peak_detector #(.REFRACT(4), .IDX_W(32)) u_dut_w (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready_w),
        .s_data     (s_data),
        .threshold  (threshold),
        .m_valid    (m_valid_w),
        .m_ready    (m_ready),
        .m_peak_val (m_peak_val_w),
        .m_peak_idx (m_peak_idx_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] thr;
        bit          emit;
        logic [31:0] val;
        int unsigned idx;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic void add(input logic [31:0] d, input logic [31:0] t, input bit e,
                                input logic [31:0] v, input int unsigned ix);
        vec_t r;
        r.data = d;
        r.thr  = t;
        r.emit = e;
        r.val  = v;
        r.idx  = ix;
        vecs.push_back(r);
    endfunction

    function automatic void add_n(input logic [31:0] d, input logic [31:0] t, input int n);
        for (int k = 0; k < n; k++) add(d, t, 1'b0, '0, 0);
    endfunction

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [31:0] d, input logic [31:0] thr);
        int waited = 0;
        s_data    = d;
        threshold = thr;
        s_valid   = 1'b1;
        while (!s_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) chk("s_ready wait", {63'd0, s_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_out(input string tag, input bit emit, input logic [31:0] val,
                             input int unsigned idx);
        chk({tag, " m_valid"}, {63'd0, m_valid}, {63'd0, emit});
        chk({tag, " m_valid_w"}, {63'd0, m_valid_w}, {63'd0, emit});
        if (emit) begin
            chk({tag, " peak_val"}, {32'd0, m_peak_val}, {32'd0, val});
            chk({tag, " peak_val_w"}, {32'd0, m_peak_val_w}, {32'd0, val});
            chk({tag, " peak_idx4"}, {60'd0, m_peak_idx}, 64'(idx % 16));
            chk({tag, " peak_idx32"}, {32'd0, m_peak_idx_w}, 64'(idx));
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " m_valid"}, {63'd0, m_valid}, 64'd0);
        chk({tag, " m_valid_w"}, {63'd0, m_valid_w}, 64'd0);
        chk({tag, " peak_val"}, {32'd0, m_peak_val}, 64'd0);
        chk({tag, " peak_idx4"}, {60'd0, m_peak_idx}, 64'd0);
        chk({tag, " peak_idx32"}, {32'd0, m_peak_idx_w}, 64'd0);
        chk({tag, " s_ready"}, {63'd0, s_ready}, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit stable;

        // Basic excursion: peak 2.0 at index 2.
        add(F_HALF, F_ONE, 0, '0, 0);
        add(F_1P5,  F_ONE, 0, '0, 0);
        add(F_TWO,  F_ONE, 0, '0, 0);
        add(F_1P5,  F_ONE, 0, '0, 0);
        add(F_HALF, F_ONE, 1, F_TWO, 2);
        add_n(F_ZERO, F_ONE, 4);                  // b5..b8, re-armed at b8
        // Tie keeps the first maximum.
        add(F_HALF, F_ONE, 0, '0, 0);             // b9
        add(F_TWO,  F_ONE, 0, '0, 0);             // b10
        add(F_TWO,  F_ONE, 0, '0, 0);
        add(F_HALF, F_ONE, 1, F_TWO, 10);         // b12
        add_n(F_ZERO, F_ONE, 4);                  // b13..b16
        // Equal to threshold does not trigger; a later drop would expose a false trigger.
        add(F_ONE,  F_ONE, 0, '0, 0);             // b17
        add(F_HALF, F_ONE, 0, '0, 0);             // b18
        // Refractory and plateau.
        add(F_TWO,  F_ONE, 0, '0, 0);             // b19
        add(F_HALF, F_ONE, 1, F_TWO, 19);         // b20
        add_n(F_TWO, F_ONE, 6);                   // b21..b26
        add(F_HALF, F_ONE, 0, '0, 0);             // b27 re-arm
        add(F_TWO,  F_ONE, 0, '0, 0);             // b28
        add(F_HALF, F_ONE, 1, F_TWO, 28);         // b29
        add_n(F_ZERO, F_ONE, 4);                  // b30..b33
        // Negative threshold; -0 is above -1.
        add(F_NTWO,  F_NONE, 0, '0, 0);           // b34
        add(F_NZERO, F_NONE, 0, '0, 0);           // b35
        add(F_NTWO,  F_NONE, 1, F_NZERO, 35);     // b36
        add_n(F_NTWO, F_NONE, 4);                 // b37..b40
        // -0 is not above +0.
        add(F_NZERO, F_ZERO, 0, '0, 0);           // b41
        add(F_NZERO, F_ZERO, 0, '0, 0);           // b42
        // +0 is above -0.
        add(F_ZERO,  F_NZERO, 0, '0, 0);          // b43
        add(F_NZERO, F_NZERO, 1, F_ZERO, 43);     // b44
        add_n(F_ZERO, F_ONE, 4);                  // b45..b48
        // Threshold raised mid-excursion terminates it on the next beat.
        add(F_TWO, F_ONE, 0, '0, 0);              // b49
        add(F_1P5, F_TWO, 1, F_TWO, 49);          // b50
        add_n(F_ZERO, F_ONE, 4);                  // b51..b54

        // Reset state.
        @(negedge clk);
        do_reset();
        check_reset_state("reset");
        rst = 1'b0;

        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].thr);
            check_out($sformatf("vec%0d", i), vecs[i].emit, vecs[i].val, vecs[i].idx);
        end

        // Backpressure: record held 50 cycles, then released with a beat in the same cycle.
        m_ready = 1'b0;
        send(F_TWO, F_ONE);                       // b55
        send(F_HALF, F_ONE);                      // b56
        check_out("bp emit", 1, F_TWO, 55);
        s_data  = F_TWO;
        s_valid = 1'b1;
        stable  = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (s_ready || !m_valid || m_peak_val !== F_TWO || m_peak_idx !== 4'(55 % 16) ||
                m_peak_idx_w !== 32'd55) stable = 1'b0;
        end
        chk("bp hold", {63'd0, stable}, 64'd1);
        m_ready = 1'b1;
        #1;
        chk("bp s_ready bypass", {63'd0, s_ready}, 64'd1);
        @(posedge clk);                           // handshake + b57
        @(negedge clk);
        s_valid = 1'b0;
        check_out("bp release", 0, '0, 0);
        send(F_TWO, F_ONE);                       // b58
        send(F_TWO, F_ONE);                       // b59
        send(F_HALF, F_ONE);                      // b60 re-arm
        send(F_TWO, F_ONE);                       // b61
        send(F_HALF, F_ONE);                      // b62
        check_out("bp next", 1, F_TWO, 61);

        // Reset with a record pending.
        for (int k = 0; k < 4; k++) send(F_ZERO, F_ONE);  // b63..b66
        m_ready = 1'b0;
        send(F_TWO, F_ONE);                       // b67
        send(F_HALF, F_ONE);                      // b68
        check_out("pend", 1, F_TWO, 67);
        do_reset();
        check_reset_state("rst pend");
        rst     = 1'b0;
        m_ready = 1'b1;

        // Reset mid-excursion; the next excursion starts fresh at index 0.
        send(F_TWO, F_ONE);
        send(F_THREE, F_ONE);
        check_out("track", 0, '0, 0);
        do_reset();
        check_reset_state("rst track");
        rst = 1'b0;
        send(F_HALF, F_ONE);
        check_out("fresh0", 0, '0, 0);
        send(F_TWO, F_ONE);
        check_out("fresh1", 0, '0, 0);
        send(F_HALF, F_ONE);
        check_out("fresh2", 1, F_TWO, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
